mod_controller_responder: RTL and testbench

Device-side end of the NES controller serial protocol: emulates a standard controller pad. It receives the latch and pulse strobes driven by a console-side reader such as mod_controller, and shifts out eight button states on the data line. It sits in the top level between an 8-bit button source (switches, a host register, or a test pattern) and the controller connector pins. It also serves as a loopback target for exercising mod_controller in simulation and on the board.

---
 rtl/mod_controller_responder.sv | 146 ++++++++++++++
 tb/tb_mod_controller_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mod_controller_responder.sv
// NES controller pad emulator: answers latch/pulse strobes from a console-side
// reader by shifting out eight active-low button states on the data line.
module mod_controller_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 24000
) (
    input  logic       in_clk_12_mhz,
    input  logic       in_reset,
    input  logic       in_controller_latch,
    input  logic       in_controller_pulse,
    input  logic [7:0] in_buttons,
    output logic       out_controller_data,
    output logic       out_busy,
    output logic       out_frame_done,
    output logic [7:0] out_poll_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCHED,
        ST_SHIFTING,
        ST_DONE
    } state_t;

    state_t        state, state_next;
    logic          latch_meta, latch_sync, latch_prev;
    logic          pulse_meta, pulse_sync, pulse_prev;
    logic [7:0]    sr, sr_next;
    logic [3:0]    idx, idx_next;
    logic [TW-1:0] tcnt, tcnt_next, tcnt_inc;
    logic          data_next, frame_done_next, busy_next;
    logic [7:0]    poll_count_next;
    logic          latch_fall, pulse_rise;

    assign latch_fall = latch_prev & ~latch_sync;
    assign pulse_rise = pulse_sync & ~pulse_prev;
    assign tcnt_inc   = tcnt + TW'(1);

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_next      = state;
        sr_next         = sr;
        idx_next        = idx;
        tcnt_next       = tcnt;
        data_next       = out_controller_data;
        frame_done_next = 1'b0;
        poll_count_next = out_poll_count;

        // Latch level wins over any pulse edge seen in the same cycle.
        if (latch_sync && state != ST_LATCHED) begin
            state_next = ST_LATCHED;
            idx_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    data_next = 1'b1;
                end
                ST_LATCHED: begin
                    sr_next   = in_buttons;
                    idx_next  = '0;
                    data_next = ~in_buttons[0];
                    if (latch_fall) begin
                        state_next = ST_SHIFTING;
                        tcnt_next  = '0;
                    end
                end
                ST_SHIFTING: begin
                    data_next = ~sr[0];
                    if (pulse_rise) begin
                        tcnt_next = '0;
                        idx_next  = idx + 4'd1;
                        sr_next   = {1'b0, sr[7:1]};
                        if (idx == 4'd7) begin
                            data_next       = 1'b1;
                            frame_done_next = 1'b1;
                            poll_count_next = out_poll_count + 8'd1;
                            state_next      = ST_DONE;
                        end else begin
                            data_next = ~sr[1];
                        end
                    end else if (tcnt_inc == TIMEOUT_LAST) begin
                        state_next = ST_IDLE;
                        data_next  = 1'b1;
                        tcnt_next  = '0;
                    end else begin
                        tcnt_next = tcnt_inc;
                    end
                end
                ST_DONE: begin
                    data_next = 1'b1;
                    if (pulse_rise) begin
                        tcnt_next = '0;
                    end else if (tcnt_inc == TIMEOUT_LAST) begin
                        state_next = ST_IDLE;
                        tcnt_next  = '0;
                    end else begin
                        tcnt_next = tcnt_inc;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        busy_next = (state_next == ST_LATCHED) || (state_next == ST_SHIFTING);
    end

    always_ff @(posedge in_clk_12_mhz) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (in_reset) begin
            latch_meta          <= 1'b0;
            latch_sync          <= 1'b0;
            latch_prev          <= 1'b0;
            pulse_meta          <= 1'b0;
            pulse_sync          <= 1'b0;
            pulse_prev          <= 1'b0;
            state               <= ST_IDLE;
            sr                  <= '0;
            idx                 <= '0;
            tcnt                <= '0;
            out_controller_data <= 1'b1;
            out_busy            <= 1'b0;
            out_frame_done      <= 1'b0;
            out_poll_count      <= '0;
        end else begin
            latch_meta          <= in_controller_latch;
            latch_sync          <= latch_meta;
            latch_prev          <= latch_sync;
            pulse_meta          <= in_controller_pulse;
            pulse_sync          <= pulse_meta;
            pulse_prev          <= pulse_sync;
            state               <= state_next;
            sr                  <= sr_next;
            idx                 <= idx_next;
            tcnt                <= tcnt_next;
            out_controller_data <= data_next;
            out_busy            <= busy_next;
            out_frame_done      <= frame_done_next;
            out_poll_count      <= poll_count_next;
        end
    end

endmodule

// File: tb/tb_mod_controller_responder.sv
// Directed bench for mod_controller_responder: table of full polls plus
// hand-written reset, abort, timeout, wrap and latch/pulse collision sequences.
`timescale 1ns/1ps
module tb_mod_controller_responder;

    localparam int TB_TIMEOUT = 200;

    logic       in_clk_12_mhz = 1'b0;
    logic       in_reset = 1'b0;
    logic       in_controller_latch = 1'b0;
    logic       in_controller_pulse = 1'b0;
    logic [7:0] in_buttons = 8'h00;
    logic       out_controller_data;
    logic       out_busy;
    logic       out_frame_done;
    logic [7:0] out_poll_count;

    mod_controller_responder #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .in_clk_12_mhz      (in_clk_12_mhz),
        .in_reset           (in_reset),
        .in_controller_latch(in_controller_latch),
        .in_controller_pulse(in_controller_pulse),
        .in_buttons         (in_buttons),
        .out_controller_data(out_controller_data),
        .out_busy           (out_busy),
        .out_frame_done     (out_frame_done),
        .out_poll_count     (out_poll_count)
    );

    always #42 in_clk_12_mhz = ~in_clk_12_mhz;

    typedef struct {
        logic [7:0]  buttons;
        int          phase;
        int          npulses;
        logic [15:0] exp_bits;
    } vec_t;

    int         n_checks = 0;
    int         n_pass = 0;
    int         fd_seen = 0;
    logic [7:0] exp_count = 8'd0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Advance n cycles, sampling frame_done once per cycle on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge in_clk_12_mhz);
            if (out_frame_done) fd_seen++;
        end
    endtask

    task automatic do_poll(input logic [7:0] b, input int ph, input int np, output logic [15:0] bits);
        bits = '1;
        in_buttons = b;
        in_controller_latch = 1'b1;
        tick(ph);
        in_controller_latch = 1'b0;
        tick(ph);
        for (int p = 0; p < np; p++) begin
            bits[p] = out_controller_data;
            in_controller_pulse = 1'b1;
            tick(ph);
            in_controller_pulse = 1'b0;
            tick(ph);
        end
    endtask

    task automatic do_reset();
        @(negedge in_clk_12_mhz);
        in_reset = 1'b1;
        in_controller_latch = 1'b1;
        in_controller_pulse = 1'b1;
        @(negedge in_clk_12_mhz);
        in_controller_latch = 1'b0;
        in_controller_pulse = 1'b0;
        @(negedge in_clk_12_mhz);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [15:0] bits;
        int          fd0;
        int          bad_bits;

        vecs[0] = '{8'hA5, 72, 8,  16'hFF5A};
        vecs[1] = '{8'h00, 6,  8,  16'hFFFF};
        vecs[2] = '{8'hFF, 6,  8,  16'hFF00};
        vecs[3] = '{8'h3C, 4,  8,  16'hFFC3};
        vecs[4] = '{8'h81, 3,  12, 16'hFF7E};

        // Reset with pins toggling, still held in reset when sampled.
        do_reset();
        check("reset_data", out_controller_data, 1'b1);
        check("reset_busy", out_busy, 1'b0);
        check("reset_frame_done", out_frame_done, 1'b0);
        check("reset_poll_count", out_poll_count, 8'd0);
        in_reset = 1'b0;
        tick(4);
        check("idle_data", out_controller_data, 1'b1);
        check("idle_busy", out_busy, 1'b0);

        for (int i = 0; i < 5; i++) begin
            fd0 = fd_seen;
            do_poll(vecs[i].buttons, vecs[i].phase, vecs[i].npulses, bits);
            exp_count = exp_count + 8'd1;
            check($sformatf("vec%0d_bits", i), bits, vecs[i].exp_bits);
            check($sformatf("vec%0d_frames", i), fd_seen - fd0, 1);
            check($sformatf("vec%0d_count", i), out_poll_count, exp_count);
            check($sformatf("vec%0d_data_idle", i), out_controller_data, 1'b1);
            check($sformatf("vec%0d_busy", i), out_busy, 1'b0);
        end

        // Abort: three pulses, then a fresh latch and a full poll.
        fd0 = fd_seen;
        do_poll(8'hFF, 6, 3, bits);
        check("abort_partial_busy", out_busy, 1'b1);
        check("abort_partial_frames", fd_seen - fd0, 0);
        check("abort_partial_count", out_poll_count, exp_count);
        do_poll(8'h01, 6, 8, bits);
        exp_count = exp_count + 8'd1;
        check("abort_bits", bits, 16'hFFFE);
        check("abort_frames", fd_seen - fd0, 1);
        check("abort_count", out_poll_count, exp_count);

        // Timeout: four pulses then silence.
        fd0 = fd_seen;
        do_poll(8'h10, 6, 4, bits);
        check("timeout_bits", bits[3:0], 4'hF);
        check("timeout_bit4_shown", out_controller_data, 1'b0);
        check("timeout_busy_before", out_busy, 1'b1);
        tick(TB_TIMEOUT - 20);
        check("timeout_busy_early", out_busy, 1'b1);
        tick(25);
        check("timeout_busy_after", out_busy, 1'b0);
        check("timeout_data_after", out_controller_data, 1'b1);
        check("timeout_frames", fd_seen - fd0, 0);
        check("timeout_count", out_poll_count, exp_count);

        // Wrap: 256 complete polls from reset.
        do_reset();
        in_reset = 1'b0;
        check("wrap_reset_count", out_poll_count, 8'd0);
        fd0 = fd_seen;
        bad_bits = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0] ^ 8'h5C;
            do_poll(b, 4, 8, bits);
            if (bits !== {8'hFF, ~b}) bad_bits++;
            if (i == 254) check("wrap_count_255", out_poll_count, 8'd255);
        end
        check("wrap_bit_errors", bad_bits, 0);
        check("wrap_frames", fd_seen - fd0, 256);
        check("wrap_count_0", out_poll_count, 8'd0);

        // Latch and pulse rise together; live button tracking while latched.
        fd0 = fd_seen;
        in_buttons = 8'h81;
        in_controller_latch = 1'b1;
        in_controller_pulse = 1'b1;
        tick(4);
        check("latch_latency_data", out_controller_data, 1'b0);
        check("latch_busy", out_busy, 1'b1);
        in_buttons = 8'h80;
        tick(1);
        check("latched_live_buttons", out_controller_data, 1'b1);
        in_controller_pulse = 1'b0;
        tick(6);
        in_controller_latch = 1'b0;
        tick(6);
        in_buttons = 8'hFF;
        tick(6);
        check("frozen_buttons", out_controller_data, 1'b1);
        bits = '1;
        for (int p = 0; p < 8; p++) begin
            bits[p] = out_controller_data;
            in_controller_pulse = 1'b1;
            tick(6);
            in_controller_pulse = 1'b0;
            tick(6);
        end
        check("collide_bits", bits, 16'hFF7F);
        check("collide_frames", fd_seen - fd0, 1);
        check("collide_count", out_poll_count, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
